alu_div_unit: RTL
=================

ALU_DIV_UNIT -- requirements
Module: alu_div_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port start  input  1  request to begin a division, sampled only when ready=1.
REQ-005 The block SHALL have port funct3  input  3  operation select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have port operand_a  input  XLEN  dividend.
REQ-007 The block SHALL have port operand_b  input  XLEN  divisor.
REQ-008 The block SHALL have port ready  output  1  high when idle and able to accept start.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking a valid Result.
REQ-010 The block SHALL have port Result  output  XLEN  quotient or remainder, held until the next accepted start.

Function
REQ-011 The block SHALL implement states IDLE, CALC and DONE.
REQ-012 In IDLE, ready=1; start=1 with funct3[2]=1 SHALL latch operands and funct3 and leave IDLE on that edge.
REQ-013 start with funct3[2]=0 SHALL be ignored; state stays IDLE.
REQ-014 start while ready=0 SHALL be ignored; latched operands are not disturbed.
REQ-015 Signed ops (DIV, REM) SHALL divide absolute values unsigned, then negate the quotient when operand signs differ and give the remainder the dividend's sign (truncating division).
REQ-016 CALC SHALL run a restoring shift-subtract, one quotient bit per cycle, for exactly XLEN cycles, counted by a log2(XLEN)+1-bit counter.
REQ-017 After the last CALC cycle the block SHALL enter DONE, assert done for one cycle, update Result, and return to IDLE on the next edge.
REQ-018 Normal latency SHALL be XLEN+1 cycles: start accepted at edge 0, done high in the cycle after edge XLEN+1 (33 for XLEN=32).
REQ-019 Divisor zero SHALL bypass CALC (IDLE->DONE): quotient all-ones, remainder = dividend, done one cycle after accept.
REQ-020 DIV/REM with dividend = most-negative and divisor = all-ones SHALL bypass CALC: quotient = dividend, remainder = 0, done one cycle after accept.
REQ-021 ready SHALL be 0 in CALC and DONE; a start coinciding with done SHALL be ignored.
REQ-022 Result SHALL change only on the edge entering DONE.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, ready=1, done=0, Result=0, counter=0, clearing all internal registers.
REQ-024 rst asserted mid-CALC SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL behave as from power-up.

Structure
REQ-025 A shared package div_pkg SHALL hold the state enum and the four funct3 encoding constants.
REQ-026 One combinational sub-module div_step SHALL perform a single restoring iteration (partial remainder, divisor in; next remainder, quotient bit out).
REQ-027 Sign handling, special-case detection, FSM and counter SHALL live in alu_div_unit.

Verification
REQ-028 DIVU 0x00000064 / 0x00000007 -> Result 0x0000000E, done exactly 33 cycles after accept, ready low throughout.
REQ-029 REM 0xFFFFFF9C / 0x00000007 -> Result 0xFFFFFFFE; DIV same operands -> 0xFFFFFFF2.
REQ-030 DIVU 0x12345678 / 0 -> 0xFFFFFFFF and REMU 0x12345678 / 0 -> 0x12345678, each done 1 cycle after accept.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0x00000000; each done 1 cycle after accept.
REQ-032 Second start with different operands at cycle 5 of CALC -> ignored, first Result unaffected; start with funct3=000 in IDLE -> ready stays 1, no done.
REQ-033 rst pulsed at cycle 10 of CALC -> ready=1, done=0, Result=0 at once, no later done; next DIVU 0x64/0x7 -> 0x0000000E.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
// Holds the controller state encoding and the funct3 operation codes
// (DIV, DIVU, REM, REMU) used by alu_div_unit and its testbench.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration (purely combinational).
// Ports:
//   rem_i          partial remainder before this step
//   dividend_bit_i next dividend bit shifted into the remainder
//   divisor_i      divisor (magnitude)
//   rem_o          partial remainder after this step
//   q_bit_o        quotient bit produced by this step
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dividend_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // One extra bit holds the shifted remainder; the top bit of the
    // difference is the borrow, i.e. "divisor did not fit".
    assign shifted = {rem_i, dividend_bit_i};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_bit_o = ~diff[XLEN];
    // When the divisor does not fit, shifted < divisor < 2^XLEN, so the
    // low XLEN bits are the whole restored remainder.
    assign rem_o   = q_bit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/alu_div_unit.sv
// Multi-cycle integer divider for DIV/DIVU/REM/REMU.
// Signed operations divide magnitudes and fix the signs afterwards
// (truncating division). Divide-by-zero and signed overflow skip the
// iteration and go straight to DONE.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, funct3       request and operation select (funct3[2] must be 1)
//   operand_a/operand_b dividend / divisor
//   ready               idle, start will be accepted
//   done                one-cycle pulse, Result valid
//   Result              quotient or remainder, held until next accepted start
module alu_div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] Result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);

    div_state_e       state_q, state_d;
    logic [XLEN-1:0]  quo_q, quo_d;     // dividend bits shifting out, quotient bits shifting in
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic            is_signed;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] step_rem;
    logic            step_q_bit;
    logic [XLEN-1:0] final_quo;
    logic [XLEN-1:0] final_rem;

    assign is_signed = (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
    // The most-negative value negates to itself, which is the correct
    // unsigned magnitude 2^(XLEN-1).
    assign abs_a = (is_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
    assign abs_b = (is_signed && operand_b[XLEN-1]) ? -operand_b : operand_b;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i          (rem_q),
        .dividend_bit_i (quo_q[XLEN-1]),
        .divisor_i      (div_q),
        .rem_o          (step_rem),
        .q_bit_o        (step_q_bit)
    );

    assign final_quo = neg_quo_q ? -quo_q : quo_q;
    assign final_rem = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        unique case (state_q)
            IDLE: begin
                if (start && funct3[2]) begin
                    quo_d     = abs_a;
                    rem_d     = '0;
                    div_d     = abs_b;
                    cnt_d     = '0;
                    is_rem_d  = funct3[1];
                    neg_quo_d = is_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                    neg_rem_d = is_signed && operand_a[XLEN-1];
                    if (operand_b == '0) begin
                        result_d = funct3[1] ? operand_a : '1;
                        state_d  = DONE;
                    end else if (is_signed && operand_a == MOST_NEG && operand_b == '1) begin
                        result_d = funct3[1] ? '0 : operand_a;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                // Counter reaching XLEN means all quotient bits are in.
                if (cnt_q == LAST_CNT) begin
                    result_d = is_rem_q ? final_rem : final_quo;
                    state_d  = DONE;
                end else begin
                    quo_d = {quo_q[XLEN-2:0], step_q_bit};
                    rem_d = step_rem;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            quo_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign Result = result_q;

endmodule
